// File: rtl/lane_pkg.sv
// Shared defaults, state encoding and frame type for the lane framer.
package lane_pkg;

    localparam int unsigned DefSymW  = 3;
    localparam int unsigned DefBeats = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StHold
    } lane_state_e;

    // Beat k lives in element [k]; bit 0 of each element is the symbol MSB.
    typedef logic [0:DefBeats-1][0:DefSymW-1] frame_t;

endpackage

// File: rtl/lane_framer_if.sv
// Symbol-in / frame-out handshake bundle for the lane framer.
interface lane_framer_if
    import lane_pkg::*;
#(
    parameter int unsigned SYM_W = DefSymW,
    parameter int unsigned BEATS = DefBeats
);

    logic [SYM_W-1:0]                sym_i;
    logic                            sym_valid_i;
    logic                            sym_ready_o;
    logic [0:BEATS-1][0:SYM_W-1]     frame_o;
    logic                            frame_valid_o;
    logic                            frame_ready_i;
    logic                            frame_err_o;
    logic [2:0]                      beat_cnt_o;

    // Producer/consumer side.
    modport master (
        output sym_i, sym_valid_i, frame_ready_i,
        input  sym_ready_o, frame_o, frame_valid_o, frame_err_o, beat_cnt_o
    );

    // Framer side.
    modport slave (
        input  sym_i, sym_valid_i, frame_ready_i,
        output sym_ready_o, frame_o, frame_valid_o, frame_err_o, beat_cnt_o
    );

endinterface

// File: rtl/lane_sym_check.sv
// Combinational X/Z scrub: unknown bits become 0 and raise a flag.
module lane_sym_check
    import lane_pkg::*;
#(
    parameter int unsigned SYM_W = DefSymW
) (
    input  logic [SYM_W-1:0] sym_i,
    output logic [SYM_W-1:0] clean_o,
    output logic             unknown_o
);

    // Only a definite 1 survives; X and Z both collapse to 0.
    always_comb begin
        clean_o   = '0;
        unknown_o = $isunknown(sym_i);
        for (int i = 0; i < SYM_W; i++) begin
            clean_o[i] = (sym_i[i] === 1'b1);
        end
    end

endmodule

// File: rtl/lane_framer.sv
// Collects BEATS symbols into one frame and holds it until the consumer takes it.
module lane_framer
    import lane_pkg::*;
#(
    parameter int unsigned SYM_W = DefSymW,
    parameter int unsigned BEATS = DefBeats
) (
    input logic         clk,
    input logic         rst_n,
    lane_framer_if.slave bus
);

    localparam logic [2:0] LastBeat = 3'(BEATS - 1);

    lane_state_e                 state_q;
    logic [2:0]                  cnt_q;
    logic [0:BEATS-1][0:SYM_W-1] frame_q;
    logic                        err_q;
    logic                        valid_q;
    logic                        ready_q;

    logic [SYM_W-1:0]            sym_clean;
    logic                        sym_unknown;
    logic                        accept;

    lane_sym_check #(
        .SYM_W (SYM_W)
    ) u_sym_check (
        .sym_i     (bus.sym_i),
        .clean_o   (sym_clean),
        .unknown_o (sym_unknown)
    );

    // ready_q is low only in HOLD, so this also blocks accepts while a frame waits.
    assign accept = bus.sym_valid_i && ready_q;

    // Framer FSM with registered outputs; leaving HOLD clears everything for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle, StCollect: begin
                    if (accept) begin
                        frame_q[cnt_q] <= sym_clean;
                        cnt_q          <= cnt_q + 3'd1;
                        err_q          <= err_q | sym_unknown;
                        if (cnt_q == LastBeat) begin
                            state_q <= StHold;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= StCollect;
                        end
                    end
                end
                StHold: begin
                    if (bus.frame_ready_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        frame_q <= '0;
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    frame_q <= '0;
                    err_q   <= 1'b0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sym_ready_o   = ready_q;
    assign bus.frame_o       = frame_q;
    assign bus.frame_valid_o = valid_q;
    assign bus.frame_err_o   = err_q;
    assign bus.beat_cnt_o    = cnt_q;

endmodule

// File: tb/tb_lane_framer.sv
// Randomized self-checking bench for lane_framer against a queue-based frame model.
module tb_lane_framer;
    import lane_pkg::*;

    localparam int unsigned W = DefSymW;
    localparam int unsigned B = DefBeats;

    logic clk;
    logic rst_n;

    lane_framer_if #(.SYM_W(W), .BEATS(B)) bus ();

    lane_framer #(
        .SYM_W (W),
        .BEATS (B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the beats accepted so far, error flag, and whether a full frame is waiting.
    logic [W-1:0] mq[$];
    bit           m_err;
    bit           m_hold;

    function automatic logic [W-1:0] scrub(input logic [W-1:0] s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (s[i] === 1'b1) ? 1'b1 : 1'b0;
        return r;
    endfunction

    function automatic bit has_unknown(input logic [W-1:0] s);
        return ((^s) === 1'bx);
    endfunction

    function automatic void model_edge(input bit r, input bit v, input logic [W-1:0] s,
                                       input bit fr);
        if (!r) begin
            mq.delete(); m_err = 0; m_hold = 0;
        end else if (m_hold) begin
            if (fr) begin mq.delete(); m_err = 0; m_hold = 0; end
        end else if (v) begin
            mq.push_back(scrub(s));
            if (has_unknown(s)) m_err = 1;
            if (mq.size() == B) m_hold = 1;
        end
    endfunction

    function automatic frame_t model_frame();
        frame_t f = '0;
        for (int k = 0; k < mq.size(); k++) f[k] = mq[k];
        return f;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] s, input bit fr);
        rst_n             = r;
        bus.sym_valid_i   = v;
        bus.sym_i         = s;
        bus.frame_ready_i = fr;
        @(posedge clk);
        model_edge(r, v, s, fr);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 3'b111, 1'b0);
        total++; if (bus.frame_valid_o !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", bus.frame_valid_o); end
        total++; if (bus.sym_ready_o !== 1'b1) begin bad++;
            $display("FAIL reset_ready: got %b want 1", bus.sym_ready_o); end
        total++; if (bus.beat_cnt_o !== 3'd0) begin bad++;
            $display("FAIL reset_cnt: got %0d want 0", bus.beat_cnt_o); end
        total++; if (bus.frame_o !== '0) begin bad++;
            $display("FAIL reset_frame: got %h want 0", bus.frame_o); end
        total++; if (bus.frame_err_o !== 1'b0) begin bad++;
            $display("FAIL reset_err: got %b want 0", bus.frame_err_o); end
    endtask

    task automatic test_basic();
        frame_t want;
        logic [W-1:0] syms [5];
        syms = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, syms[k], 1'b0);
            if (k < 4) begin
                total++; if (bus.beat_cnt_o !== 3'(k + 1) || bus.frame_valid_o !== 1'b0) begin
                    bad++; $display("FAIL basic_collect: cnt %0d valid %b want cnt %0d valid 0",
                                    bus.beat_cnt_o, bus.frame_valid_o, k + 1); end
            end
        end
        for (int k = 0; k < 5; k++) want[k] = syms[k];
        total++; if (bus.frame_valid_o !== 1'b1) begin bad++;
            $display("FAIL basic_valid: got %b want 1", bus.frame_valid_o); end
        total++; if (bus.frame_o !== want) begin bad++;
            $display("FAIL basic_frame: got %h want %h", bus.frame_o, want); end
        total++; if (bus.frame_err_o !== 1'b0 || bus.sym_ready_o !== 1'b0) begin bad++;
            $display("FAIL basic_err_ready: got err %b ready %b want 0 0",
                     bus.frame_err_o, bus.sym_ready_o); end
        total++; if (bus.beat_cnt_o !== 3'd5) begin bad++;
            $display("FAIL basic_cnt: got %0d want 5", bus.beat_cnt_o); end
    endtask

    task automatic test_hold();
        frame_t want;
        want = model_frame();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 1'b1, 3'($urandom), 1'b0);
            total++; if (bus.frame_o !== want || bus.frame_valid_o !== 1'b1 ||
                         bus.beat_cnt_o !== 3'd5) begin bad++;
                $display("FAIL hold_stable: frame %h valid %b cnt %0d want %h 1 5",
                         bus.frame_o, bus.frame_valid_o, bus.beat_cnt_o, want); end
        end
        cycle(1'b1, 1'b1, 3'b110, 1'b1);
        total++; if (bus.beat_cnt_o !== 3'd0 || bus.frame_valid_o !== 1'b0 ||
                     bus.frame_err_o !== 1'b0) begin bad++;
            $display("FAIL hold_release: cnt %0d valid %b err %b want 0 0 0",
                     bus.beat_cnt_o, bus.frame_valid_o, bus.frame_err_o); end
        total++; if (bus.frame_o !== '0 || bus.sym_ready_o !== 1'b1) begin bad++;
            $display("FAIL hold_no_accept: frame %h ready %b want 0 1",
                     bus.frame_o, bus.sym_ready_o); end
    endtask

    task automatic test_xbeat();
        logic [W-1:0] s;
        bit want_err;
        for (int k = 0; k < 5; k++) begin
            s = (k == 2) ? 3'b1x0 : 3'($urandom);
            cycle(1'b1, 1'b1, s, 1'b0);
        end
        want_err = m_err;
        total++; if (bus.frame_o[2] !== 3'b100) begin bad++;
            $display("FAIL xbeat_scrub: got %b want 100", bus.frame_o[2]); end
        total++; if (bus.frame_err_o !== want_err || bus.frame_o !== model_frame()) begin bad++;
            $display("FAIL xbeat_err: err %b frame %h want %b %h",
                     bus.frame_err_o, bus.frame_o, want_err, model_frame()); end
        cycle(1'b1, 1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 3'($urandom), 1'b0);
        total++; if (bus.frame_err_o !== 1'b0 || bus.frame_o !== model_frame() ||
                     bus.frame_valid_o !== 1'b1) begin bad++;
            $display("FAIL xbeat_clean_next: err %b frame %h valid %b want 0 %h 1",
                     bus.frame_err_o, bus.frame_o, bus.frame_valid_o, model_frame()); end
        cycle(1'b1, 1'b0, 3'b000, 1'b1);
    endtask

    task automatic test_reset_mid();
        frame_t want;
        bit saw_valid = 0;
        cycle(1'b1, 1'b1, 3'b010, 1'b0);
        cycle(1'b1, 1'b1, 3'b011, 1'b0);
        cycle(1'b0, 1'b1, 3'b001, 1'b0);
        total++; if (bus.beat_cnt_o !== 3'd0 || bus.frame_o !== '0) begin bad++;
            $display("FAIL midreset_clear: cnt %0d frame %h want 0 0",
                     bus.beat_cnt_o, bus.frame_o); end
        for (int k = 0; k < 5; k++) begin
            if (bus.frame_valid_o === 1'b1) saw_valid = 1;
            cycle(1'b1, 1'b1, 3'b111, 1'b0);
        end
        for (int k = 0; k < 5; k++) want[k] = 3'b111;
        total++; if (saw_valid || bus.frame_o !== want || bus.frame_valid_o !== 1'b1) begin
            bad++; $display("FAIL midreset_frame: early %b frame %h valid %b want 0 %h 1",
                            saw_valid, bus.frame_o, bus.frame_valid_o, want); end
        // Reset while a frame is held must drop it.
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        total++; if (bus.frame_valid_o !== 1'b0 || bus.frame_o !== '0 ||
                     bus.sym_ready_o !== 1'b1) begin bad++;
            $display("FAIL holdreset: valid %b frame %h ready %b want 0 0 1",
                     bus.frame_valid_o, bus.frame_o, bus.sym_ready_o); end
    endtask

    task automatic test_gaps();
        frame_t want;
        logic [W-1:0] s;
        for (int k = 0; k < 5; k++) begin
            int gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b1, 1'b0, 3'bxxx, 1'b0);
                total++; if (bus.beat_cnt_o !== 3'(k) || bus.frame_o !== model_frame()) begin
                    bad++; $display("FAIL gap_idle: cnt %0d frame %h want %0d %h",
                                    bus.beat_cnt_o, bus.frame_o, k, model_frame()); end
            end
            s = 3'($urandom);
            want[k] = s;
            cycle(1'b1, 1'b1, s, 1'b0);
        end
        total++; if (bus.frame_o !== want || bus.frame_err_o !== 1'b0 ||
                     bus.frame_valid_o !== 1'b1) begin bad++;
            $display("FAIL gap_frame: frame %h err %b valid %b want %h 0 1",
                     bus.frame_o, bus.frame_err_o, bus.frame_valid_o, want); end
        cycle(1'b1, 1'b0, 3'b000, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        bit v, fr, r;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(49, 0) != 0);
            v  = ($urandom_range(3, 0) != 0);
            fr = ($urandom_range(3, 0) == 0);
            s  = 3'($urandom);
            if ($urandom_range(15, 0) == 0) s[$urandom_range(W - 1, 0)] = 1'bx;
            cycle(r, v, s, fr);
            total++; if (bus.frame_o !== model_frame() || bus.frame_valid_o !== m_hold ||
                         bus.sym_ready_o !== !m_hold || bus.frame_err_o !== m_err ||
                         bus.beat_cnt_o !== 3'(mq.size())) begin bad++;
                $display("FAIL random_c%0d: frame %h v %b rdy %b err %b cnt %0d want %h %b %b %b %0d",
                         c, bus.frame_o, bus.frame_valid_o, bus.sym_ready_o, bus.frame_err_o,
                         bus.beat_cnt_o, model_frame(), m_hold, !m_hold, m_err, mq.size()); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sym_valid_i = 1'b0;
        bus.sym_i = '0;
        bus.frame_ready_i = 1'b0;
        m_err = 0;
        m_hold = 0;
        test_reset();
        test_basic();
        test_hold();
        test_xbeat();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_framer.md
LANE_FRAMER -- requirements
Module: lane_framer

Interface
REQ-001 Parameter SYM_W, default 3: width of one input symbol in bits.
REQ-002 Parameter BEATS, default 5: number of symbols per frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sym_i  input  logic [SYM_W-1:0]  incoming symbol, 4-state.
REQ-006 sym_valid_i  input  1  sym_i carries a symbol this cycle.
REQ-007 sym_ready_o  output  1  block accepts a symbol this cycle.
REQ-008 frame_o  output  logic [0:BEATS-1][0:SYM_W-1]  assembled frame, beat k in element [k].
REQ-009 frame_valid_o  output  1  frame_o holds a complete frame.
REQ-010 frame_ready_i  input  1  consumer takes frame_o this cycle.
REQ-011 frame_err_o  output  1  current frame contained at least one X/Z symbol bit; qualified by frame_valid_o.
REQ-012 beat_cnt_o  output  [2:0]  number of symbols accepted into the frame under assembly.

Function
REQ-013 Symbol accept SHALL occur exactly when sym_valid_i and sym_ready_o are both 1 at a rising edge.
REQ-014 States SHALL be IDLE (no beats), COLLECT (1..BEATS-1 beats), HOLD (frame complete, awaiting consumer).
REQ-015 sym_ready_o SHALL be 1 in IDLE and COLLECT and 0 in HOLD.
REQ-016 Accepted symbol SHALL be written to frame_o[beat_cnt_o] and beat_cnt_o SHALL increment by 1.
REQ-017 IDLE -> COLLECT on an accept; COLLECT -> HOLD on the accept that brings the count to BEATS; beat_cnt_o SHALL then read BEATS in HOLD.
REQ-018 frame_valid_o SHALL be 1 exactly while in HOLD, rising the cycle after the BEATS-th accept (latency 1).
REQ-019 frame_o and frame_err_o SHALL remain stable throughout HOLD.
REQ-020 HOLD -> IDLE on frame_ready_i=1; beat_cnt_o SHALL be 0, frame_valid_o 0 and frame_err_o 0 the next cycle; no symbol SHALL be accepted in that HOLD cycle.
REQ-021 frame_ready_i SHALL be ignored outside HOLD.
REQ-022 An accepted symbol with any X or Z bit SHALL be stored with those bits as 0 and SHALL set the frame error flag, sticky until the frame leaves HOLD.
REQ-023 sym_i SHALL be ignored whenever sym_valid_i=0, including X/Z values.
REQ-024 Gaps (sym_valid_i=0) between beats SHALL not alter state, count or stored beats.
REQ-025 Not-yet-written elements of frame_o SHALL read 0 during IDLE/COLLECT.

Reset
REQ-026 When rst_n=0 at a rising edge, the next state SHALL be IDLE, beat_cnt_o 0, frame_o all 0, frame_valid_o 0, frame_err_o 0, sym_ready_o 1.
REQ-027 Reset asserted mid-COLLECT or in HOLD SHALL discard the partial or pending frame without emitting it.
REQ-028 No symbol SHALL be accepted in a cycle where rst_n=0.

Structure
REQ-029 Package lane_pkg SHALL hold SYM_W and BEATS defaults, the state enum (IDLE, COLLECT, HOLD) and the frame typedef.
REQ-030 Sub-module lane_sym_check SHALL be purely combinational, producing the X/Z-cleaned symbol and a 1-bit unknown flag.
REQ-031 All sequential logic SHALL reside in lane_framer, in a single clocked process.

Verification
REQ-032 Reset then 5 back-to-back symbols 3'b001,3'b010,3'b011,3'b100,3'b101 with frame_ready_i=0 -> frame_valid_o=1 next cycle, frame_o={001,010,011,100,101}, frame_err_o=0, sym_ready_o=0.
REQ-033 Hold frame_ready_i=0 for 10 cycles while sym_valid_i=1 -> frame_o unchanged and no accepts; then frame_ready_i=1 for 1 cycle -> next cycle IDLE, beat_cnt_o=0.
REQ-034 Third beat 3'b1x0 -> frame_o[2]=3'b100, frame_err_o=1 in HOLD; following frame clean -> frame_err_o=0.
REQ-035 Two beats, rst_n=0 for 1 cycle, then 5 beats of 3'b111 -> single frame all 3'b111, no frame from the discarded beats.
REQ-036 Beats separated by random 0-3 idle cycles, with X on sym_i during idles -> frame identical to gap-free case, frame_err_o=0.
